// File: rtl/apb2axi_pkg.sv
// Shared AXI constants and the read-directory entry layout for the APB-to-AXI bridge.
package apb2axi_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ID_NUM = 2 ** AXI_ID_W;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   tag;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
  } directory_entry_t;

  localparam int REQ_WIDTH = $bits(directory_entry_t);

endpackage

// File: rtl/apb2axi_rd_tag_tracker.sv
// In-flight tag bitmap, per-tag error accumulation, outstanding count and completion pulse.
// APB2AXI_RD_BEAT_CHECK_EN adds per-tag beat counters that catch early or missing rlast.
module apb2axi_rd_tag_tracker
  import apb2axi_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
`ifdef APB2AXI_RD_BEAT_CHECK_EN
  , parameter int LEN_W         = 4
`endif
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  pop,
  input  logic [AXI_ID_W-1:0]   pop_tag,
`ifdef APB2AXI_RD_BEAT_CHECK_EN
  input  logic [LEN_W-1:0]      pop_len,
`endif
  input  logic                  r_accept,
  input  logic [AXI_ID_W-1:0]   r_id,
  input  logic                  r_err,
  input  logic                  r_last,
  output logic [AXI_ID_NUM-1:0] inflight,
  output logic [OUT_W-1:0]      outstanding,
  output logic                  cmpl_valid,
  output logic [AXI_ID_W-1:0]   cmpl_tag,
  output logic                  cmpl_err,
  output logic                  unexp_id
);

  localparam logic [OUT_W-1:0] CNT_ONE = OUT_W'(1);

  logic [AXI_ID_NUM-1:0] err_acc;
  logic                  r_hit;
  logic                  complete;
  logic                  beat_err;
  logic                  err_now;

  assign r_hit = r_accept && inflight[r_id];

`ifdef APB2AXI_RD_BEAT_CHECK_EN
  localparam logic [LEN_W:0] ONE_BEAT = (LEN_W + 1)'(1);

  logic [LEN_W:0] beats_left [AXI_ID_NUM];
  logic           final_beat;

  assign final_beat = (beats_left[r_id] == ONE_BEAT);
  // Early rlast and a missing rlast on the last expected beat both end the read as an error.
  assign beat_err   = (final_beat != r_last);
  assign complete   = r_hit && (r_last || final_beat);

  // NOTE: beats_left is a storage array loaded at every pop before it is ever read,
  // so it carries no reset; only state observable after reset is reset.
  always_ff @(posedge aclk) begin
    if (r_hit && !complete)
      beats_left[r_id] <= beats_left[r_id] - ONE_BEAT;
    if (pop)
      beats_left[pop_tag] <= (LEN_W + 1)'(pop_len) + ONE_BEAT;
  end
`else
  assign beat_err = 1'b0;
  assign complete = r_hit && r_last;
`endif

  assign err_now = err_acc[r_id] | r_err | beat_err;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      inflight    <= '0;
      err_acc     <= '0;
      outstanding <= '0;
      cmpl_valid  <= 1'b0;
      cmpl_tag    <= '0;
      cmpl_err    <= 1'b0;
      unexp_id    <= 1'b0;
    end else begin
      cmpl_valid <= complete;
      if (complete) begin
        inflight[r_id] <= 1'b0;
        err_acc[r_id]  <= 1'b0;
        cmpl_tag       <= r_id;
        cmpl_err       <= err_now;
      end else if (r_hit) begin
        err_acc[r_id] <= err_acc[r_id] | r_err;
      end
      // A pop on the tag completing this cycle wins, leaving it in flight.
      if (pop)
        inflight[pop_tag] <= 1'b1;

      case ({pop, complete})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase

      if (r_accept && !inflight[r_id])
        unexp_id <= 1'b1;
    end
  end

endmodule

// File: rtl/apb2axi_read_engine.sv
// Read engine: pops directory entries, issues AXI AR bursts, forwards R beats, emits completions.
// Optional build macro APB2AXI_RD_BEAT_CHECK_EN enables per-tag beat-count checking.
module apb2axi_read_engine
  import apb2axi_pkg::*;
#(
  parameter int FIFO_ENTRY_W    = REQ_WIDTH,
  parameter int LEN_W           = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  rd_pop_valid,
  input  logic [FIFO_ENTRY_W-1:0] rd_pop_data,
  output logic                  rd_pop_ready,
  output logic [AXI_ID_W-1:0]   arid,
  output logic [AXI_ADDR_W-1:0] araddr,
  output logic [LEN_W-1:0]      arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [AXI_ID_W-1:0]   rid,
  input  logic [AXI_DATA_W-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  rd_data_valid,
  output logic [AXI_ID_W-1:0]   rd_data_tag,
  output logic [AXI_DATA_W-1:0] rd_data,
  output logic [1:0]            rd_data_resp,
  output logic                  rd_data_last,
  input  logic                  rd_data_ready,
  output logic                  rd_cmpl_valid,
  output logic [AXI_ID_W-1:0]   rd_cmpl_tag,
  output logic                  rd_cmpl_err,
  output logic [OUT_W-1:0]      rd_outstanding,
  output logic                  rd_unexp_id
);

  localparam logic [OUT_W-1:0] MAX_CNT = OUT_W'(MAX_OUTSTANDING);

  directory_entry_t      entry;
  logic                  pop;
  logic [AXI_ID_NUM-1:0] inflight;

  assign entry = directory_entry_t'(rd_pop_data);

  // Held low during reset so the FIFO never sees a handshake while tracking is cleared.
  assign rd_pop_ready = aresetn && (!arvalid || arready) && (rd_outstanding < MAX_CNT)
                        && !inflight[entry.tag];
  assign pop = rd_pop_valid && rd_pop_ready;

  assign arlock  = 1'b0;
  assign arcache = 4'b0011;
  assign arprot  = 3'b000;

  // NOTE: registered state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      arvalid <= 1'b0;
      arid    <= '0;
      araddr  <= '0;
      arlen   <= '0;
      arsize  <= '0;
      arburst <= '0;
    end else if (pop) begin
      arvalid <= 1'b1;
      arid    <= entry.tag;
      araddr  <= entry.addr;
      arlen   <= LEN_W'(entry.len);
      arsize  <= entry.size;
      arburst <= AXI_BURST_INCR;
    end else if (arready) begin
      arvalid <= 1'b0;
    end
  end

  assign rd_data_valid = rvalid;
  assign rd_data_tag   = rid;
  assign rd_data       = rdata;
  assign rd_data_resp  = rresp;
  assign rd_data_last  = rlast;
  assign rready        = rd_data_ready;

  apb2axi_rd_tag_tracker #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .OUT_W           (OUT_W)
`ifdef APB2AXI_RD_BEAT_CHECK_EN
    , .LEN_W         (LEN_W)
`endif
  ) u_tag_tracker (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .pop         (pop),
    .pop_tag     (entry.tag),
`ifdef APB2AXI_RD_BEAT_CHECK_EN
    .pop_len     (LEN_W'(entry.len)),
`endif
    .r_accept    (rvalid && rd_data_ready),
    .r_id        (rid),
    .r_err       (rresp[1]),
    .r_last      (rlast),
    .inflight    (inflight),
    .outstanding (rd_outstanding),
    .cmpl_valid  (rd_cmpl_valid),
    .cmpl_tag    (rd_cmpl_tag),
    .cmpl_err    (rd_cmpl_err),
    .unexp_id    (rd_unexp_id)
  );

endmodule

// File: tb/tb_apb2axi_read_engine.sv
// Directed self-checking bench for apb2axi_read_engine (default parameters: LEN_W=4, MAX_OUTSTANDING=4).
module tb_apb2axi_read_engine;
  import apb2axi_pkg::*;

`ifdef APB2AXI_RD_BEAT_CHECK_EN
  localparam logic EARLY_LAST_ERR = 1'b1;
`else
  localparam logic EARLY_LAST_ERR = 1'b0;
`endif

  logic                  aclk = 1'b0;
  logic                  aresetn;
  logic                  rd_pop_valid;
  logic [REQ_WIDTH-1:0]  rd_pop_data;
  logic                  rd_pop_ready;
  logic [AXI_ID_W-1:0]   arid;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [3:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [AXI_ID_W-1:0]   rid;
  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;
  logic                  rd_data_valid;
  logic [AXI_ID_W-1:0]   rd_data_tag;
  logic [AXI_DATA_W-1:0] rd_data;
  logic [1:0]            rd_data_resp;
  logic                  rd_data_last;
  logic                  rd_data_ready;
  logic                  rd_cmpl_valid;
  logic [AXI_ID_W-1:0]   rd_cmpl_tag;
  logic                  rd_cmpl_err;
  logic [2:0]            rd_outstanding;
  logic                  rd_unexp_id;

  int n_checks = 0;
  int n_fails  = 0;
  int ar_cnt   = 0;
  int ar_base;

  apb2axi_read_engine dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .rd_pop_valid   (rd_pop_valid),
    .rd_pop_data    (rd_pop_data),
    .rd_pop_ready   (rd_pop_ready),
    .arid           (arid),
    .araddr         (araddr),
    .arlen          (arlen),
    .arsize         (arsize),
    .arburst        (arburst),
    .arlock         (arlock),
    .arcache        (arcache),
    .arprot         (arprot),
    .arvalid        (arvalid),
    .arready        (arready),
    .rid            (rid),
    .rdata          (rdata),
    .rresp          (rresp),
    .rlast          (rlast),
    .rvalid         (rvalid),
    .rready         (rready),
    .rd_data_valid  (rd_data_valid),
    .rd_data_tag    (rd_data_tag),
    .rd_data        (rd_data),
    .rd_data_resp   (rd_data_resp),
    .rd_data_last   (rd_data_last),
    .rd_data_ready  (rd_data_ready),
    .rd_cmpl_valid  (rd_cmpl_valid),
    .rd_cmpl_tag    (rd_cmpl_tag),
    .rd_cmpl_err    (rd_cmpl_err),
    .rd_outstanding (rd_outstanding),
    .rd_unexp_id    (rd_unexp_id)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk)
    if (aresetn && arvalid && arready) ar_cnt++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic set_entry(input logic [3:0] tag, input logic [31:0] addr, input logic [7:0] len);
    directory_entry_t e;
    e = '{tag: tag, addr: addr, len: len, size: 3'd2};
    rd_pop_data = e;
  endtask

  // Presents one entry and waits (bounded) for the handshake; returns at posedge+1 after it.
  task automatic push(input logic [3:0] tag, input logic [31:0] addr, input logic [7:0] len);
    int waited = 0;
    set_entry(tag, addr, len);
    rd_pop_valid = 1'b1;
    #1;
    while (!rd_pop_ready && waited < 50) begin
      @(posedge aclk); #1;
      waited++;
    end
    check("pop_accept", rd_pop_ready, 1);
    @(posedge aclk); #1;
    rd_pop_valid = 1'b0;
  endtask

  // One accepted R beat; checks the pass-through and returns at posedge+1 after acceptance.
  task automatic r_beat(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp,
                        input logic last);
    rvalid = 1'b1; rid = id; rdata = data; rresp = resp; rlast = last; rd_data_ready = 1'b1;
    #1;
    check("r_passthru", {rd_data_valid, rd_data_tag, rd_data, rd_data_resp, rd_data_last},
          {1'b1, id, data, resp, last});
    check("rready", rready, 1);
    @(posedge aclk); #1;
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic check_cmpl(input string name, input logic [3:0] tag, input logic err);
    check(name, {rd_cmpl_valid, rd_cmpl_tag, rd_cmpl_err}, {1'b1, tag, err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0; rd_pop_valid = 1'b0; rd_pop_data = '0; arready = 1'b1;
    rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0; rd_data_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst_arvalid", arvalid, 0);
    check("rst_pop_ready", rd_pop_ready, 0);
    check("rst_outstanding", rd_outstanding, 0);
    check("rst_cmpl_unexp", {rd_cmpl_valid, rd_unexp_id}, 0);
    check("rst_ar_payload", {arid, araddr, arlen, arsize, arburst}, 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Single read: tag 2, addr 0x1000, len 3
    ar_base = ar_cnt;
    push(4'd2, 32'h1000, 8'd3);
    check("single_ar_payload", {arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot},
          {1'b1, 4'd2, 32'h1000, 4'd3, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
    check("single_outstanding", rd_outstanding, 1);
    @(posedge aclk); #1;
    check("single_ar_done", arvalid, 0);
    check("single_ar_count", ar_cnt - ar_base, 1);
    for (int i = 0; i < 4; i++) begin
      r_beat(4'd2, 32'hA000 + i, AXI_RESP_OKAY, i == 3);
      if (i < 3) check("single_no_cmpl", rd_cmpl_valid, 0);
    end
    check_cmpl("single_cmpl", 4'd2, 1'b0);
    check("single_outstanding_end", rd_outstanding, 0);
    @(posedge aclk); #1;
    check("single_cmpl_pulse", rd_cmpl_valid, 0);

    // Outstanding limit: four accepted, fifth stalls until one completes
    ar_base = ar_cnt;
    for (int t = 0; t < 4; t++) push(4'(t), 32'h100 * t, 8'd0);
    set_entry(4'd4, 32'h400, 8'd0);
    rd_pop_valid = 1'b1;
    repeat (3) begin
      @(posedge aclk); #1;
      check("full_pop_ready", rd_pop_ready, 0);
    end
    check("full_outstanding", rd_outstanding, 4);
    check("full_ar_count", ar_cnt - ar_base, 4);
    r_beat(4'd0, 32'hB000, AXI_RESP_OKAY, 1'b1);
    check_cmpl("full_cmpl_tag0", 4'd0, 1'b0);
    check("full_pop_ready_freed", rd_pop_ready, 1);
    @(posedge aclk); #1;
    rd_pop_valid = 1'b0;
    check("full_fifth_ar", {arvalid, arid, rd_outstanding}, {1'b1, 4'd4, 3'd4});
    @(posedge aclk); #1;
    check("full_ar_count5", ar_cnt - ar_base, 5);
    for (int t = 1; t < 5; t++) r_beat(4'(t), 32'hB100 + t, AXI_RESP_OKAY, 1'b1);
    check("full_drained", rd_outstanding, 0);

    // AR backpressure: payload stable, no second pop
    arready = 1'b0;
    push(4'd6, 32'h2000, 8'd1);
    set_entry(4'd7, 32'h2100, 8'd0);
    rd_pop_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("arbp_stable", {arvalid, arid, araddr, arlen}, {1'b1, 4'd6, 32'h2000, 4'd1});
      check("arbp_no_pop", rd_pop_ready, 0);
      @(posedge aclk); #1;
    end
    arready = 1'b1;
    #1;
    check("arbp_release_ready", rd_pop_ready, 1);
    @(posedge aclk); #1;
    rd_pop_valid = 1'b0;
    check("arbp_second_ar", {arvalid, arid, araddr}, {1'b1, 4'd7, 32'h2100});

    // R backpressure: no completion while rd_data_ready is low
    r_beat(4'd6, 32'hC000, AXI_RESP_OKAY, 1'b0);
    rvalid = 1'b1; rid = 4'd6; rdata = 32'hC001; rresp = AXI_RESP_OKAY; rlast = 1'b1;
    rd_data_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rbp_rready_low", {rready, rd_data_valid}, {1'b0, 1'b1});
      @(posedge aclk); #1;
      check("rbp_no_cmpl", rd_cmpl_valid, 0);
    end
    rd_data_ready = 1'b1;
    @(posedge aclk); #1;
    rvalid = 1'b0; rlast = 1'b0;
    check_cmpl("rbp_cmpl", 4'd6, 1'b0);
    r_beat(4'd7, 32'hC100, AXI_RESP_OKAY, 1'b1);
    check_cmpl("rbp_cmpl_tag7", 4'd7, 1'b0);

    // Error accumulation: beat 2 of 4 is SLVERR, then a clean read on the same tag
    push(4'd8, 32'h3000, 8'd3);
    for (int i = 0; i < 4; i++)
      r_beat(4'd8, 32'hD000 + i, (i == 1) ? AXI_RESP_SLVERR : AXI_RESP_OKAY, i == 3);
    check_cmpl("err_cmpl", 4'd8, 1'b1);
    push(4'd8, 32'h3100, 8'd1);
    r_beat(4'd8, 32'hD100, AXI_RESP_OKAY, 1'b0);
    r_beat(4'd8, 32'hD101, AXI_RESP_OKAY, 1'b1);
    check_cmpl("err_cleared", 4'd8, 1'b0);

    // Duplicate tag stalls until the first read on that tag completes
    push(4'd5, 32'h4000, 8'd0);
    set_entry(4'd5, 32'h4100, 8'd0);
    rd_pop_valid = 1'b1;
    repeat (3) begin
      @(posedge aclk); #1;
      check("dup_stall", rd_pop_ready, 0);
    end
    r_beat(4'd5, 32'hE000, AXI_RESP_OKAY, 1'b1);
    check_cmpl("dup_cmpl_first", 4'd5, 1'b0);
    check("dup_ready_after", rd_pop_ready, 1);
    @(posedge aclk); #1;
    rd_pop_valid = 1'b0;
    check("dup_second_ar", {arvalid, araddr, rd_outstanding}, {1'b1, 32'h4100, 3'd1});
    r_beat(4'd5, 32'hE001, AXI_RESP_OKAY, 1'b1);
    check_cmpl("dup_cmpl_second", 4'd5, 1'b0);

    // Unexpected rid: forwarded, flagged, counters untouched
    push(4'd12, 32'h4200, 8'd0);
    r_beat(4'd7, 32'hF000, AXI_RESP_OKAY, 1'b1);
    check("unexp_flag", rd_unexp_id, 1);
    check("unexp_count", {rd_outstanding, rd_cmpl_valid}, {3'd1, 1'b0});
    r_beat(4'd12, 32'hF001, AXI_RESP_OKAY, 1'b1);
    check_cmpl("unexp_tag12_cmpl", 4'd12, 1'b0);
    check("unexp_sticky", rd_unexp_id, 1);

    // Early rlast: error only when beat checking is built in
    push(4'd9, 32'h5000, 8'd3);
    r_beat(4'd9, 32'h5A00, AXI_RESP_OKAY, 1'b0);
    r_beat(4'd9, 32'h5A01, AXI_RESP_OKAY, 1'b1);
    check_cmpl("early_last", 4'd9, EARLY_LAST_ERR);
    check("early_last_count", rd_outstanding, 0);
`ifdef APB2AXI_RD_BEAT_CHECK_EN
    push(4'd10, 32'h5100, 8'd1);
    r_beat(4'd10, 32'h5B00, AXI_RESP_OKAY, 1'b0);
    r_beat(4'd10, 32'h5B01, AXI_RESP_OKAY, 1'b0);
    check_cmpl("missing_last", 4'd10, 1'b1);
    check("missing_last_count", rd_outstanding, 0);
`endif

    // Reset mid-burst drops tracking; late beats are unexpected
    push(4'd11, 32'h6000, 8'd3);
    r_beat(4'd11, 32'h6A00, AXI_RESP_OKAY, 1'b0);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    check("midrst_state", {rd_outstanding, rd_unexp_id, arvalid, rd_pop_ready}, 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    r_beat(4'd11, 32'h6A01, AXI_RESP_OKAY, 1'b0);
    check("midrst_unexp", rd_unexp_id, 1);
    check("midrst_count", {rd_outstanding, rd_cmpl_valid}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
